multicycle_ctrl: RTL and testbench

//   Multi-cycle main control FSM for the MIPS core. Sequences one instruction at a

---
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the MIPS core.
// Sequences one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.
// It drives the datapath selects, handshakes with the unified memory port
// through mem_ready, and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ir_we,
  output logic [1:0]       ext_op,
  output logic             alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             mem_re,
  output logic             mem_we,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_MEMWB  = 3'd4,
    S_ALUWB  = 3'd5,
    S_RST    = 3'd6
  } state_t;

  // reg_dst=10 steers the register-file write address to LINK_REG in the datapath.
  if (LINK_REG < 0 || LINK_REG > 31) begin : g_link_reg_range
    $error("LINK_REG must name one of the 32 architectural registers");
  end

  state_t cur, nxt;
  logic   cnt_inc;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_rtype, is_addu, is_subu, is_jr;
  logic       is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic       is_legal;
  logic [1:0] ext_sel;
  logic       unused_instr;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign is_rtype = (opcode == 6'h00);
  assign is_addu  = is_rtype && (funct == 6'h21);
  assign is_subu  = is_rtype && (funct == 6'h23);
  assign is_jr    = is_rtype && (funct == 6'h08);
  assign is_ori   = (opcode == 6'h0d);
  assign is_lui   = (opcode == 6'h0f);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2b);
  assign is_beq   = (opcode == 6'h04);
  assign is_j     = (opcode == 6'h02);
  assign is_jal   = (opcode == 6'h03);
  assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui |
                    is_lw | is_sw | is_beq | is_j | is_jal;

  // Extender mode is a pure function of the opcode so it stays stable from
  // EXEC through the following MEM or ALUWB cycle.
  assign ext_sel = is_ori ? 2'b01 : (is_lui ? 2'b10 : 2'b00);

  // Register-number and shamt fields are consumed by the datapath, not here.
  assign unused_instr = ^instr[25:6];

  assign state = cur;

  // State register; reset forces RST immediately, abandoning any memory access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_RST;
    else        cur <= nxt;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       instr_cnt <= '0;
    else if (cnt_inc) instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state and Moore/decode outputs; every output defaults to 0.
  always_comb begin
    nxt       = cur;
    cnt_inc   = 1'b0;
    pc_we     = 1'b0;
    npc_sel   = 2'b00;
    ir_we     = 1'b0;
    ext_op    = 2'b00;
    alu_src_b = 1'b0;
    alu_op    = 3'b000;
    reg_we    = 1'b0;
    reg_dst   = 2'b00;
    wd_sel    = 2'b00;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    illegal   = 1'b0;
    case (cur)
      S_RST: nxt = S_FETCH;
      S_FETCH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_j) begin
          pc_we   = 1'b1;
          npc_sel = 2'b10;
          nxt     = S_FETCH;
          cnt_inc = 1'b1;
        end else if (is_jal) begin
          pc_we   = 1'b1;
          npc_sel = 2'b10;
          reg_we  = 1'b1;
          reg_dst = 2'b10;
          wd_sel  = 2'b10;
          nxt     = S_FETCH;
          cnt_inc = 1'b1;
        end else if (is_jr) begin
          pc_we   = 1'b1;
          npc_sel = 2'b11;
          nxt     = S_FETCH;
          cnt_inc = 1'b1;
        end else if (!is_legal) begin
          // Unsupported encodings are dropped without retiring.
          illegal = 1'b1;
          nxt     = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        ext_op = ext_sel;
        if (is_addu || is_subu) begin
          alu_op = is_subu ? 3'b001 : 3'b000;
          nxt    = S_ALUWB;
        end else if (is_ori) begin
          alu_src_b = 1'b1;
          alu_op    = 3'b010;
          nxt       = S_ALUWB;
        end else if (is_lui) begin
          alu_src_b = 1'b1;
          alu_op    = 3'b011;
          nxt       = S_ALUWB;
        end else if (is_lw || is_sw) begin
          alu_src_b = 1'b1;
          alu_op    = 3'b000;
          nxt       = S_MEM;
        end else begin
          // beq resolves here; any other encoding only arrives if IR changed
          // under us, and falls back to FETCH the same way.
          alu_op  = is_beq ? 3'b001 : 3'b000;
          pc_we   = is_beq & zero;
          npc_sel = is_beq ? 2'b01 : 2'b00;
          nxt     = S_FETCH;
          cnt_inc = 1'b1;
        end
      end
      S_MEM: begin
        ext_op = ext_sel;
        mem_re = is_lw;
        mem_we = is_sw & ~is_lw;
        if (mem_ready) begin
          nxt     = is_lw ? S_MEMWB : S_FETCH;
          cnt_inc = ~is_lw;
        end
      end
      S_MEMWB: begin
        reg_we  = 1'b1;
        reg_dst = 2'b00;
        wd_sel  = 2'b01;
        nxt     = S_FETCH;
        cnt_inc = 1'b1;
      end
      S_ALUWB: begin
        ext_op  = ext_sel;
        reg_we  = 1'b1;
        wd_sel  = 2'b00;
        reg_dst = is_rtype ? 2'b01 : 2'b00;
        nxt     = S_FETCH;
        cnt_inc = 1'b1;
      end
      default: nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Each instruction is expanded into its expected cycle-by-cycle trace from the
// instruction-level rules, then replayed against the DUT with $urandom timing.
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;
  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic             pc_we, ir_we, alu_src_b, reg_we, mem_re, mem_we, illegal;
  logic [1:0]       npc_sel, ext_op, reg_dst, wd_sel;
  logic [2:0]       alu_op, state;
  logic [CNT_W-1:0] instr_cnt;
  logic [17:0]      ov_dut;

  int ncmp = 0;
  int nerr = 0;
  logic [CNT_W-1:0] cnt_exp;

  typedef struct packed {
    logic [2:0]  st;
    logic        mr;
    logic        z;
    logic [17:0] ov;
  } cyc_t;

  cyc_t q[$];

  multicycle_ctrl #(.CNT_W(CNT_W), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .ext_op(ext_op),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .mem_re(mem_re), .mem_we(mem_we), .illegal(illegal),
    .state(state), .instr_cnt(instr_cnt)
  );

  assign ov_dut = {pc_we, npc_sel, ir_we, ext_op, alu_src_b, alu_op,
                   reg_we, reg_dst, wd_sel, mem_re, mem_we, illegal};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] mk(input logic pw, input logic [1:0] ns, input logic iw,
                                     input logic [1:0] ex, input logic asb, input logic [2:0] ao,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] wd,
                                     input logic mr, input logic mw, input logic il);
    return {pw, ns, iw, ex, asb, ao, rw, rd, wd, mr, mw, il};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic cyc_t mkc(input logic [2:0] st, input logic mr, input logic z,
                               input logic [17:0] ov);
    cyc_t c;
    c.st = st; c.mr = mr; c.z = z; c.ov = ov;
    return c;
  endfunction

  function automatic logic [31:0] enc(input int k);
    logic [31:0] r;
    r = $urandom();
    case (k)
      K_ADDU: return {6'h00, r[25:6], 6'h21};
      K_SUBU: return {6'h00, r[25:6], 6'h23};
      K_JR:   return {6'h00, r[25:6], 6'h08};
      K_ORI:  return {6'h0d, r[25:0]};
      K_LUI:  return {6'h0f, r[25:0]};
      K_LW:   return {6'h23, r[25:0]};
      K_SW:   return {6'h2b, r[25:0]};
      K_BEQ:  return {6'h04, r[25:0]};
      K_J:    return {6'h02, r[25:0]};
      K_JAL:  return {6'h03, r[25:0]};
      default: begin
        case ($urandom_range(5, 0))
          0:       return {6'h3f, r[25:0]};
          1:       return {6'h08, r[25:0]};
          2:       return {6'h05, r[25:0]};
          3:       return {6'h20, r[25:0]};
          4:       return {6'h00, r[25:6], 6'h20};
          default: return {6'h00, r[25:6], 6'h2a};
        endcase
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected trace of one instruction: fw FETCH stalls, mw MEM stalls, z = ALU zero in EXEC.
  task automatic build_q(input int k, input int fw, input int mw, input logic z);
    logic [1:0] ex;
    ex = (k == K_ORI) ? 2'b01 : (k == K_LUI) ? 2'b10 : 2'b00;
    q.delete();
    for (int i = 0; i < fw; i++)
      q.push_back(mkc(3'd0, L, rb(), mk(L,2'b00,L,2'b00,L,3'b000,L,2'b00,2'b00,H,L,L)));
    q.push_back(mkc(3'd0, H, rb(), mk(H,2'b00,H,2'b00,L,3'b000,L,2'b00,2'b00,H,L,L)));
    case (k)
      K_J:   begin q.push_back(mkc(3'd1, rb(), rb(), mk(H,2'b10,L,2'b00,L,3'b000,L,2'b00,2'b00,L,L,L))); return; end
      K_JAL: begin q.push_back(mkc(3'd1, rb(), rb(), mk(H,2'b10,L,2'b00,L,3'b000,H,2'b10,2'b10,L,L,L))); return; end
      K_JR:  begin q.push_back(mkc(3'd1, rb(), rb(), mk(H,2'b11,L,2'b00,L,3'b000,L,2'b00,2'b00,L,L,L))); return; end
      K_ILL: begin q.push_back(mkc(3'd1, rb(), rb(), mk(L,2'b00,L,2'b00,L,3'b000,L,2'b00,2'b00,L,L,H))); return; end
      default: q.push_back(mkc(3'd1, rb(), rb(), '0));
    endcase
    case (k)
      K_ADDU: q.push_back(mkc(3'd2, rb(), rb(), mk(L,2'b00,L,ex,L,3'b000,L,2'b00,2'b00,L,L,L)));
      K_SUBU: q.push_back(mkc(3'd2, rb(), rb(), mk(L,2'b00,L,ex,L,3'b001,L,2'b00,2'b00,L,L,L)));
      K_ORI:  q.push_back(mkc(3'd2, rb(), rb(), mk(L,2'b00,L,ex,H,3'b010,L,2'b00,2'b00,L,L,L)));
      K_LUI:  q.push_back(mkc(3'd2, rb(), rb(), mk(L,2'b00,L,ex,H,3'b011,L,2'b00,2'b00,L,L,L)));
      K_BEQ:  begin q.push_back(mkc(3'd2, rb(), z, mk(z,2'b01,L,ex,L,3'b001,L,2'b00,2'b00,L,L,L))); return; end
      default: q.push_back(mkc(3'd2, rb(), rb(), mk(L,2'b00,L,ex,H,3'b000,L,2'b00,2'b00,L,L,L)));
    endcase
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= mw; i++)
        q.push_back(mkc(3'd3, (i == mw), rb(),
                        mk(L,2'b00,L,ex,L,3'b000,L,2'b00,2'b00,(k == K_LW),(k == K_SW),L)));
      if (k == K_LW)
        q.push_back(mkc(3'd4, rb(), rb(), mk(L,2'b00,L,2'b00,L,3'b000,H,2'b00,2'b01,L,L,L)));
    end else begin
      q.push_back(mkc(3'd5, rb(), rb(),
                      mk(L,2'b00,L,ex,L,3'b000,H,(k <= K_SUBU) ? 2'b01 : 2'b00,2'b00,L,L,L)));
    end
  endtask

  // Drive one cycle's inputs just after the edge, check on the falling edge.
  task automatic play(input cyc_t c, input int k, input int idx);
    mem_ready = c.mr;
    zero      = c.z;
    @(negedge clk);
    check($sformatf("state k%0d c%0d", k, idx), 32'(state), 32'(c.st));
    check($sformatf("outs k%0d c%0d", k, idx), 32'(ov_dut), 32'(c.ov));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int k, input logic [31:0] w, input int fw, input int mw,
                           input logic z);
    int idx;
    instr = w;
    build_q(k, fw, mw, z);
    idx = 0;
    while (q.size() > 0) begin
      play(q.pop_front(), k, idx);
      idx++;
    end
    if (k != K_ILL) cnt_exp = cnt_exp + 1;
    check($sformatf("cnt k%0d", k), instr_cnt, cnt_exp);
  endtask

  initial begin
    cyc_t c;
    int   k, fw, mw;
    reset = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    cnt_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd6);
    check("rst_outs", 32'(ov_dut), 32'd0);
    check("rst_cnt", instr_cnt, 32'd0);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_exit_state", 32'(state), 32'd6);
    check("rst_exit_outs", 32'(ov_dut), 32'd0);
    @(posedge clk);
    #1;

    // addu $3,$1,$2 straight out of reset
    run_instr(K_ADDU, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 0, 0, 1'b0);
    // lw with three MEM stall cycles
    run_instr(K_LW, enc(K_LW), 0, 3, 1'b0);
    run_instr(K_ORI, enc(K_ORI), 0, 0, 1'b0);
    run_instr(K_LUI, enc(K_LUI), 0, 0, 1'b0);
    run_instr(K_BEQ, enc(K_BEQ), 0, 0, 1'b1);
    run_instr(K_BEQ, enc(K_BEQ), 0, 0, 1'b0);
    run_instr(K_JAL, enc(K_JAL), 0, 0, 1'b0);
    run_instr(K_ILL, {6'h3f, 26'h0}, 0, 0, 1'b0);
    run_instr(K_SUBU, enc(K_SUBU), 2, 0, 1'b0);
    run_instr(K_J, enc(K_J), 1, 0, 1'b0);
    run_instr(K_JR, enc(K_JR), 0, 0, 1'b0);

    // reset pulled while a store is waiting in MEM
    instr = enc(K_SW);
    build_q(K_SW, 0, 3, 1'b0);
    for (int i = 0; i < 3; i++) play(q.pop_front(), K_SW, i);
    c = q.pop_front();
    mem_ready = 1'b0;
    zero      = c.z;
    @(negedge clk);
    check("abort_pre_state", 32'(state), 32'(c.st));
    check("abort_pre_outs", 32'(ov_dut), 32'(c.ov));
    #1 reset = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd6);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_outs", 32'(ov_dut), 32'd0);
    check("abort_cnt", instr_cnt, 32'd0);
    cnt_exp = '0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("abort_hold_outs", 32'(ov_dut), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_rst_state", 32'(state), 32'd6);
    @(posedge clk);
    #1;
    run_instr(K_SW, enc(K_SW), 0, 1, 1'b0);

    // randomized instruction mix with random stalls
    for (int n = 0; n < 300; n++) begin
      k  = int'($urandom_range(10, 0));
      fw = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      mw = ($urandom_range(2, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
      run_instr(k, enc(k), fw, mw, rb());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
